speck_round_key_store: RTL and testbench
========================================

Name: speck_round_key_store

Overview:
- Iterative SPECK128/128 key expander with a round-key buffer.
- Sits between the 128-bit master key input and the round_decrypt / round_encrypt chain.
- Computes all NR_ROUNDS 64-bit round keys once and stores them in a register file.
- Replays them one per handshake, forward for encryption or reverse for decryption, so one round datapath can iterate without a per-round key_schedule instance.

Parameters:
- NR_ROUNDS, 32, number of round keys (takes its default from `NR_ROUNDS in cipher_settings.vh)
- BLOCK_SIZE, 64, word width, one round key (`BLOCK_SIZE)
- KEY_SIZE, 128, master key width (`KEY_SIZE)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- key_valid  in  1  master key offered
- key_ready  out  1  block can accept a key; high in IDLE and LOADED
- key  in  KEY_SIZE  master key {l0, k0}; k0 = key[63:0], l0 = key[127:64]
- loaded  out  1  all round keys valid in buffer
- rk_start  in  1  begin a replay; sampled only while loaded and not replaying
- rk_decrypt  in  1  replay direction, sampled with rk_start: 1 = index NR_ROUNDS-1 down to 0, 0 = index 0 up to NR_ROUNDS-1
- rk_valid  out  1  round_key and rk_index valid
- rk_next  in  1  consumer takes the current key
- round_key  out  BLOCK_SIZE  current round key
- rk_index  out  5  index of the current key
- rk_last  out  1  current key is the final one of the replay

Behaviour:
- Reset (async): state IDLE; key_ready=1; loaded=0; rk_valid=0; rk_last=0; round_key=0; rk_index=0; buffer and l register cleared.
- FSM states: IDLE, EXPAND, LOADED, REPLAY.
- IDLE/LOADED to EXPAND on key_valid & key_ready:
  - buf[0] <= k0; l <= l0; i <= 0; loaded <= 0.
  - A new key accepted in LOADED discards the old buffer.
- EXPAND, one key per cycle:
  - l_n = (k_i + ROR(l,8)) ^ i, modulo 2^64 add, i zero-extended to 64 bits.
  - k_{i+1} = ROL(k_i,3) ^ l_n.
  - Writes buf[i+1]; i increments.
  - After the cycle that writes buf[NR_ROUNDS-1], go to LOADED with loaded=1.
  - Total latency from key acceptance edge to loaded=1 is NR_ROUNDS-1 = 31 cycles.
  - key_ready=0 throughout; key_valid is ignored.
- LOADED to REPLAY on rk_start:
  - Start pointer is NR_ROUNDS-1 if rk_decrypt, else 0.
  - rk_valid rises the next cycle, with round_key = buf[ptr] registered.
  - rk_start and key_valid in the same cycle: key_valid wins; rk_start is dropped.
- REPLAY:
  - rk_valid held high; outputs stable until rk_next.
  - On rk_next the pointer steps by -1 (decrypt) or +1 (encrypt); the new key is presented the following cycle.
  - rk_next on the key with rk_last=1: rk_valid <= 0, return to LOADED. The buffer is retained and replays may repeat without re-expansion.
  - rk_next while rk_valid=0 is ignored.
  - The pointer never wraps.
  - key_valid is ignored in REPLAY (key_ready=0).
- rk_last = rk_valid & (ptr == 0 for decrypt, ptr == NR_ROUNDS-1 for encrypt).
- rst mid-EXPAND or mid-REPLAY: immediate return to reset values; partial buffer is discarded.

Optional Feature:
- SPECK_KS_ZEROIZE_EN defined:
  - On the rk_next that completes a replay, all buffer entries clear to 0, loaded <= 0, and the block returns to IDLE.
  - Each key is single-use.
- Not defined: the buffer is retained and the block returns to LOADED as above.

Decomposition:
- Shared package/include (cipher_settings.vh): NR_ROUNDS, BLOCK_SIZE, KEY_SIZE, ALPHA=8, BETA=3, FSM state encodings.
- One natural sub-module: speck_ks_step, a combinational single key-schedule step (k, l, i -> k_next, l_next), reusable by the existing key_schedule.

Test Plan:
1. Expansion values:
   - Stimulus: key = 0x0f0e0d0c0b0a0908_0706050403020100.
   - Response: loaded exactly 31 cycles after acceptance; forward replay gives rk_index 0 key 0x0706050403020100 and rk_index 1 key 0x37253b31171d0309.
2. Decrypt replay:
   - Stimulus: rk_start with rk_decrypt=1, rk_next held high.
   - Response: indices 31..0 on 32 consecutive valid cycles; rk_last only at index 0; keys equal the forward replay reversed; state returns to LOADED.
3. Backpressure:
   - Stimulus: drop rk_next for 5 cycles at index 10.
   - Response: round_key and rk_index stable at 10; no skipped or repeated index.
4. Reset mid-operation:
   - Stimulus: assert rst at EXPAND cycle 12, then at replay index 7.
   - Response: same cycle, all outputs at reset values; key_ready=1; loaded=0.
5. Collision and rekey:
   - Stimulus: in LOADED, assert key_valid and rk_start together with a new key.
   - Response: no replay starts; re-expansion occurs; new buf[0] equals the new k0.
6. Zeroize on/off:
   - Stimulus: complete one replay with SPECK_KS_ZEROIZE_EN defined, then repeat undefined.
   - Response: defined gives loaded=0 and IDLE, and a second rk_start produces no rk_valid. Undefined gives a second replay identical to the first.

Source files
------------

// File: rtl/speck_round_key_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : speck_round_key_store_pkg
//  Description : Shared SPECK128/128 key-schedule constants and the state
//                encoding of the round-key store controller.
//  Revision    : 1.0  initial release
// ============================================================================
package speck_round_key_store_pkg;

    localparam int C_NR_ROUNDS  = 32;   // number of round keys
    localparam int C_BLOCK_SIZE = 64;   // word width, one round key
    localparam int C_KEY_SIZE   = 128;  // master key width {l0, k0}
    localparam int C_ALPHA      = 8;    // right rotation applied to l
    localparam int C_BETA       = 3;    // left rotation applied to k
    localparam int C_IDX_W      = 5;    // round-index width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_LOADED = 2'd2,
        ST_REPLAY = 2'd3
    } ks_state_t;

endpackage
`default_nettype wire

// File: rtl/speck_round_key_store_ks_step.sv
`default_nettype none
// ============================================================================
//  Module      : speck_ks_step
//  Description : One combinational SPECK key-schedule step:
//                  l_next = (k + ROR(l, ALPHA)) ^ i
//                  k_next = ROL(k, BETA) ^ l_next
//  Revision    : 1.0  initial release
// ============================================================================
module speck_ks_step
    import speck_round_key_store_pkg::*;
#(
    parameter int BLOCK_SIZE = C_BLOCK_SIZE,
    parameter int IDX_W      = C_IDX_W
) (
    input  logic [BLOCK_SIZE-1:0] i_k,
    input  logic [BLOCK_SIZE-1:0] i_l,
    input  logic [IDX_W-1:0]      i_round,
    output logic [BLOCK_SIZE-1:0] o_k_next,
    output logic [BLOCK_SIZE-1:0] o_l_next
);

    logic [BLOCK_SIZE-1:0] w_l_ror;
    logic [BLOCK_SIZE-1:0] w_k_rol;
    logic [BLOCK_SIZE-1:0] w_round_ext;

    assign w_l_ror     = {i_l[C_ALPHA-1:0], i_l[BLOCK_SIZE-1:C_ALPHA]};
    assign w_k_rol     = {i_k[BLOCK_SIZE-C_BETA-1:0], i_k[BLOCK_SIZE-1:BLOCK_SIZE-C_BETA]};
    assign w_round_ext = {{(BLOCK_SIZE-IDX_W){1'b0}}, i_round};

    // Modulo-2^W add, then round-counter injection, then key mixing
    assign o_l_next = (i_k + w_l_ror) ^ w_round_ext;
    assign o_k_next = w_k_rol ^ o_l_next;

endmodule
`default_nettype wire

// File: rtl/speck_round_key_store.sv
`default_nettype none
// ============================================================================
//  Module      : speck_round_key_store
//  Description : Iterative SPECK128/128 key expander with a round-key buffer.
//                Expands all round keys once (one per cycle), then replays
//                them one per handshake, forward (encrypt) or reverse
//                (decrypt).
//                Build option SPECK_KS_ZEROIZE_EN: wipe the buffer and return
//                to IDLE after each completed replay (single-use keys).
//  Revision    : 1.0  initial release
// ============================================================================
module speck_round_key_store
    import speck_round_key_store_pkg::*;
#(
    parameter int NR_ROUNDS  = C_NR_ROUNDS,
    parameter int BLOCK_SIZE = C_BLOCK_SIZE,
    parameter int KEY_SIZE   = C_KEY_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [KEY_SIZE-1:0]   key,
    output logic                  loaded,
    input  logic                  rk_start,
    input  logic                  rk_decrypt,
    output logic                  rk_valid,
    input  logic                  rk_next,
    output logic [BLOCK_SIZE-1:0] round_key,
    output logic [C_IDX_W-1:0]    rk_index,
    output logic                  rk_last
);

    localparam logic [C_IDX_W-1:0] C_LAST_IDX   = C_IDX_W'(NR_ROUNDS - 1);
    localparam logic [C_IDX_W-1:0] C_EXP_FINAL  = C_IDX_W'(NR_ROUNDS - 2);

    ks_state_t             r_state;
    ks_state_t             w_state_next;

    logic [BLOCK_SIZE-1:0] r_buf [NR_ROUNDS];
    logic [BLOCK_SIZE-1:0] r_k;
    logic [BLOCK_SIZE-1:0] r_l;
    logic [C_IDX_W-1:0]    r_i;
    logic                  r_loaded;

    logic [C_IDX_W-1:0]    r_ptr;
    logic                  r_dec;
    logic                  r_valid;
    logic [BLOCK_SIZE-1:0] r_round_key;

    logic [BLOCK_SIZE-1:0] w_k_next;
    logic [BLOCK_SIZE-1:0] w_l_next;
    logic                  w_accept;
    logic                  w_expand;
    logic                  w_exp_done;
    logic                  w_start;
    logic                  w_step;
    logic                  w_last;
    logic                  w_finish;
    logic                  w_zeroize;
    logic [C_IDX_W-1:0]    w_start_ptr;
    logic [C_IDX_W-1:0]    w_step_ptr;

    speck_ks_step #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .IDX_W      (C_IDX_W)
    ) u_ks_step (
        .i_k      (r_k),
        .i_l      (r_l),
        .i_round  (r_i),
        .o_k_next (w_k_next),
        .o_l_next (w_l_next)
    );

    // Handshake and control decode; a key offer always beats rk_start
    assign key_ready   = (r_state == ST_IDLE) || (r_state == ST_LOADED);
    assign w_accept    = key_valid & key_ready;
    assign w_expand    = (r_state == ST_EXPAND);
    assign w_exp_done  = w_expand & (r_i == C_EXP_FINAL);
    assign w_start     = (r_state == ST_LOADED) & rk_start & ~key_valid;
    assign w_last      = r_valid & (r_dec ? (r_ptr == '0) : (r_ptr == C_LAST_IDX));
    assign w_step      = (r_state == ST_REPLAY) & r_valid & rk_next;
    assign w_finish    = w_step & w_last;
    assign w_start_ptr = rk_decrypt ? C_LAST_IDX : '0;
    assign w_step_ptr  = r_dec ? (r_ptr - 1'b1) : (r_ptr + 1'b1);

`ifdef SPECK_KS_ZEROIZE_EN
    assign w_zeroize = w_finish;
`else
    assign w_zeroize = 1'b0;
`endif

    assign loaded    = r_loaded;
    assign rk_valid  = r_valid;
    assign round_key = r_round_key;
    assign rk_index  = r_ptr;
    assign rk_last   = w_last;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_EXPAND;
            end
            ST_EXPAND: begin
                if (w_exp_done) w_state_next = ST_LOADED;
            end
            ST_LOADED: begin
                if (w_accept)     w_state_next = ST_EXPAND;
                else if (w_start) w_state_next = ST_REPLAY;
            end
            ST_REPLAY: begin
                if (w_finish) w_state_next = w_zeroize ? ST_IDLE : ST_LOADED;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Expansion registers: working k/l pair, round counter and loaded flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k      <= '0;
            r_l      <= '0;
            r_i      <= '0;
            r_loaded <= 1'b0;
        end else if (w_accept) begin
            r_k      <= key[BLOCK_SIZE-1:0];
            r_l      <= key[KEY_SIZE-1:BLOCK_SIZE];
            r_i      <= '0;
            r_loaded <= 1'b0;
        end else if (w_expand) begin
            r_k <= w_k_next;
            r_l <= w_l_next;
            r_i <= r_i + 1'b1;
            if (w_exp_done) r_loaded <= 1'b1;
        end else if (w_zeroize) begin
            r_loaded <= 1'b0;
        end
    end

    // Round-key buffer: k0 on acceptance, then entry i+1 each expansion cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NR_ROUNDS; j++) r_buf[j] <= '0;
        end else if (w_zeroize) begin
            for (int j = 0; j < NR_ROUNDS; j++) r_buf[j] <= '0;
        end else if (w_accept) begin
            r_buf[0] <= key[BLOCK_SIZE-1:0];
        end else if (w_expand) begin
            r_buf[r_i + 1'b1] <= w_k_next;
        end
    end

    // Replay pointer and registered key output; pointer holds on the last key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_dec       <= 1'b0;
            r_valid     <= 1'b0;
            r_round_key <= '0;
        end else if (w_start) begin
            r_ptr       <= w_start_ptr;
            r_dec       <= rk_decrypt;
            r_valid     <= 1'b1;
            r_round_key <= r_buf[w_start_ptr];
        end else if (w_step) begin
            if (w_last) begin
                r_valid <= 1'b0;
            end else begin
                r_ptr       <= w_step_ptr;
                r_round_key <= r_buf[w_step_ptr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_speck_round_key_store.sv
`default_nettype none
// ============================================================================
//  Module      : tb_speck_round_key_store
//  Description : Directed self-checking bench for speck_round_key_store.
//                Expectations follow SPECKS_KS_ZEROIZE_EN-dependent behaviour
//                when the bench is built with SPECK_KS_ZEROIZE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_speck_round_key_store;

    localparam int NR = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         loaded;
    logic         rk_start;
    logic         rk_decrypt;
    logic         rk_valid;
    logic         rk_next;
    logic [63:0]  round_key;
    logic [4:0]   rk_index;
    logic         rk_last;

    int checks = 0;
    int errors = 0;

    logic [63:0] gold  [NR];
    logic [63:0] cap   [NR];
    logic [63:0] fwd   [NR];
    logic [63:0] first [NR];

    localparam logic [127:0] KEY1 = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KEY2 = 128'h1918111009080100_0123456789abcdef;

`ifdef SPECK_KS_ZEROIZE_EN
    localparam logic EXP_LOADED_AFTER = 1'b0;
`else
    localparam logic EXP_LOADED_AFTER = 1'b1;
`endif

    speck_round_key_store dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .loaded     (loaded),
        .rk_start   (rk_start),
        .rk_decrypt (rk_decrypt),
        .rk_valid   (rk_valid),
        .rk_next    (rk_next),
        .round_key  (round_key),
        .rk_index   (rk_index),
        .rk_last    (rk_last)
    );

    always #5 clk = ~clk;

    // Reference SPECK128/128 key schedule
    task automatic build_gold(input logic [127:0] mk);
        logic [63:0] k, l, ln;
        k = mk[63:0];
        l = mk[127:64];
        gold[0] = k;
        for (int i = 0; i < NR - 1; i++) begin
            ln = (k + {l[7:0], l[63:8]}) ^ 64'(i);
            k  = {k[60:0], k[63:61]} ^ ln;
            l  = ln;
            gold[i+1] = k;
        end
    endtask

    // Offer a key for one cycle, then count cycles until loaded (bounded)
    task automatic load_key(input logic [127:0] mk, output int lat);
        @(negedge clk);
        key       = mk;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        lat = 0;
        while (!loaded && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        build_gold(mk);
    endtask

    // Full replay with rk_next held high; captures presented keys into cap[]
    task automatic run_replay(input logic dec);
        int e;
        @(negedge clk);
        rk_decrypt = dec;
        rk_start   = 1'b1;
        rk_next    = 1'b1;
        @(negedge clk);
        rk_start   = 1'b0;
        for (int s = 0; s < NR; s++) begin
            e = dec ? (NR - 1 - s) : s;
            checks++;
            if (rk_valid !== 1'b1 || rk_index !== 5'(e) || round_key !== gold[e]) begin
                errors++;
                $display("FAIL replay dec=%0b step %0d: valid=%b idx=%0d key=%h, required valid=1 idx=%0d key=%h",
                         dec, s, rk_valid, rk_index, round_key, e, gold[e]);
            end
            checks++;
            if (rk_last !== (s == NR - 1)) begin
                errors++;
                $display("FAIL rk_last dec=%0b step %0d: got %b, required %b", dec, s, rk_last, (s == NR - 1));
            end
            cap[e] = round_key;
            @(negedge clk);
        end
        rk_next = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1 || loaded !== EXP_LOADED_AFTER) begin
            errors++;
            $display("FAIL replay_end dec=%0b: valid=%b key_ready=%b loaded=%b, required 0 1 %b",
                     dec, rk_valid, key_ready, loaded, EXP_LOADED_AFTER);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_valid = 1'b0; key = '0; rk_start = 1'b0; rk_decrypt = 1'b0; rk_next = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || loaded !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0 ||
            round_key !== 64'h0 || rk_index !== 5'd0) begin
            errors++;
            $display("FAIL reset_values: ready=%b loaded=%b valid=%b last=%b key=%h idx=%0d, required 1 0 0 0 0 0",
                     key_ready, loaded, rk_valid, rk_last, round_key, rk_index);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_expand();
        int lat;
        load_key(KEY1, lat);
        checks++;
        if (lat !== 31) begin
            errors++;
            $display("FAIL expand_latency: got %0d cycles, required 31", lat);
        end
        run_replay(1'b0);
        checks++;
        if (cap[0] !== 64'h0706050403020100) begin
            errors++;
            $display("FAIL rk0: got %h, required 0706050403020100", cap[0]);
        end
        checks++;
        if (cap[1] !== 64'h37253b31171d0309) begin
            errors++;
            $display("FAIL rk1: got %h, required 37253b31171d0309", cap[1]);
        end
        for (int j = 0; j < NR; j++) fwd[j] = cap[j];
    endtask

    task automatic test_decrypt();
        int lat;
        load_key(KEY1, lat);
        run_replay(1'b1);
        for (int j = 0; j < NR; j++) begin
            checks++;
            if (cap[j] !== fwd[j]) begin
                errors++;
                $display("FAIL dec_vs_fwd idx %0d: got %h, required %h", j, cap[j], fwd[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, e, hold, budget;
        load_key(KEY1, lat);
        @(negedge clk);
        rk_decrypt = 1'b0;
        rk_start   = 1'b1;
        rk_next    = 1'b0;
        @(negedge clk);
        rk_start = 1'b0;
        e = 0; hold = 0; budget = 0;
        while (e < NR && budget < 100) begin
            budget++;
            checks++;
            if (rk_valid !== 1'b1 || rk_index !== 5'(e) || round_key !== gold[e]) begin
                errors++;
                $display("FAIL backpressure idx: valid=%b idx=%0d key=%h, required valid=1 idx=%0d key=%h",
                         rk_valid, rk_index, round_key, e, gold[e]);
            end
            if (e == 10 && hold < 5) begin
                rk_next = 1'b0;
                hold++;
            end else begin
                rk_next = 1'b1;
                e++;
            end
            @(negedge clk);
        end
        rk_next = 1'b0;
        checks++;
        if (e != NR || hold != 5 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_end: reached %0d held %0d valid=%b, required 32 5 0", e, hold, rk_valid);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        // Reset during expansion
        @(negedge clk);
        key = KEY2; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (key_ready !== 1'b0 || loaded !== 1'b0) begin
            errors++;
            $display("FAIL mid_expand: ready=%b loaded=%b, required 0 0", key_ready, loaded);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b1 || loaded !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0 ||
            round_key !== 64'h0 || rk_index !== 5'd0) begin
            errors++;
            $display("FAIL rst_expand: ready=%b loaded=%b valid=%b last=%b key=%h idx=%0d, required 1 0 0 0 0 0",
                     key_ready, loaded, rk_valid, rk_last, round_key, rk_index);
        end
        @(negedge clk);
        rst = 1'b0;
        rk_start = 1'b1;
        repeat (3) @(negedge clk);
        rk_start = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || loaded !== 1'b0) begin
            errors++;
            $display("FAIL start_after_rst: valid=%b loaded=%b, required 0 0", rk_valid, loaded);
        end
        // Reset during replay at index 7
        begin
            int lat;
            load_key(KEY1, lat);
        end
        @(negedge clk);
        rk_decrypt = 1'b0; rk_start = 1'b1; rk_next = 1'b1;
        @(negedge clk);
        rk_start = 1'b0;
        budget = 0;
        while (!(rk_valid === 1'b1 && rk_index === 5'd7) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (budget >= 50) begin
            errors++;
            $display("FAIL reach_idx7: got idx=%0d valid=%b, required idx 7 valid 1", rk_index, rk_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b1 || loaded !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0 ||
            round_key !== 64'h0 || rk_index !== 5'd0) begin
            errors++;
            $display("FAIL rst_replay: ready=%b loaded=%b valid=%b last=%b key=%h idx=%0d, required 1 0 0 0 0 0",
                     key_ready, loaded, rk_valid, rk_last, round_key, rk_index);
        end
        rk_next = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_collision();
        int lat, budget;
        load_key(KEY1, lat);
        @(negedge clk);
        key = KEY2; key_valid = 1'b1; rk_start = 1'b1; rk_decrypt = 1'b0;
        @(negedge clk);
        key_valid = 1'b0; rk_start = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || loaded !== 1'b0 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision: valid=%b loaded=%b ready=%b, required 0 0 0", rk_valid, loaded, key_ready);
        end
        budget = 0;
        while (!loaded && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (loaded !== 1'b1) begin
            errors++;
            $display("FAIL rekey_loaded: got %b, required 1", loaded);
        end
        build_gold(KEY2);
        run_replay(1'b0);
        checks++;
        if (cap[0] !== KEY2[63:0]) begin
            errors++;
            $display("FAIL rekey_k0: got %h, required %h", cap[0], KEY2[63:0]);
        end
    endtask

    task automatic test_zeroize();
        int lat;
        load_key(KEY1, lat);
        run_replay(1'b0);
        for (int j = 0; j < NR; j++) first[j] = cap[j];
`ifdef SPECK_KS_ZEROIZE_EN
        @(negedge clk);
        rk_start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rk_valid !== 1'b0 || loaded !== 1'b0) begin
                errors++;
                $display("FAIL zeroize_restart cycle %0d: valid=%b loaded=%b, required 0 0", c, rk_valid, loaded);
            end
        end
        rk_start = 1'b0;
`else
        run_replay(1'b0);
        for (int j = 0; j < NR; j++) begin
            checks++;
            if (cap[j] !== first[j]) begin
                errors++;
                $display("FAIL second_replay idx %0d: got %h, required %h", j, cap[j], first[j]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_expand();
        test_decrypt();
        test_backpressure();
        test_reset_mid();
        test_collision();
        test_zeroize();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
